// File: rtl/rv_div_ctrl_if.sv
// Bundle of the issue-side request/result signals and the divider-core
// handshake for rv_div_ctrl. The controller uses the slave modport; the
// surrounding pipeline plus divider core use the master modport.
interface rv_div_ctrl_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  // issue side
  logic             req_vld_i;
  logic             req_rdy_o;
  logic [1:0]       op_i;
  logic             word_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  // writeback side
  logic             res_vld_o;
  logic [XLEN-1:0]  res_o;
  logic [TAG_W-1:0] res_tag_o;
  logic             busy_o;
  // divider core side
  logic             div_vld_o;
  logic [XLEN-1:0]  div_op1_o;
  logic [XLEN-1:0]  div_op2_o;
  logic             div_ready_i;
  logic [XLEN-1:0]  div_quo_i;
  logic [XLEN-1:0]  div_rem_i;

  modport master (
    output req_vld_i, op_i, word_i, rs1_i, rs2_i, tag_i, flush_i,
    output div_ready_i, div_quo_i, div_rem_i,
    input  req_rdy_o, res_vld_o, res_o, res_tag_o, busy_o,
    input  div_vld_o, div_op1_o, div_op2_o
  );

  modport slave (
    input  req_vld_i, op_i, word_i, rs1_i, rs2_i, tag_i, flush_i,
    input  div_ready_i, div_quo_i, div_rem_i,
    output req_rdy_o, res_vld_o, res_o, res_tag_o, busy_o,
    output div_vld_o, div_op1_o, div_op2_o
  );
endinterface

// File: rtl/rv_div_ctrl.sv
// Execute-stage requester for the radix-4 SRT divider core. Handles RV64M
// DIV/DIVU/REM/REMU (and W forms): resolves divide-by-zero, signed overflow
// and large unsigned divisors locally, splits unsigned dividends with the MSB
// set into a shifted core divide plus one correction step, and returns one
// tagged writeback result.
module rv_div_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input logic          clk,
  input logic          rst,
  rv_div_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIX,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state;
  logic             req_rdy;
  logic             res_vld_q;
  logic [XLEN-1:0]  res_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             busy;
  logic             div_vld;
  logic [XLEN-1:0]  div_op1;
  logic [XLEN-1:0]  div_op2;

  logic             rem_sel_q;
  logic             word_q;
  logic [TAG_W-1:0] tag_q;
  logic             split_q;
  logic             seen_q;
  logic             lsb_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;

  logic             sgn;
  logic [XLEN-1:0]  op1_p;
  logic [XLEN-1:0]  op2_p;
  logic             div0;
  logic             ovf;
  logic             ubig;
  logic             special;
  logic             split;
  logic [XLEN-1:0]  sq;
  logic [XLEN-1:0]  sr;

  logic [XLEN-1:0]  r2;
  logic [XLEN-1:0]  fix_q;
  logic [XLEN-1:0]  fix_r;

  // Select quotient or remainder; W forms always sign-extend bit 31.
  function automatic logic [XLEN-1:0] pick(input logic rem_sel, input logic word,
                                           input logic [XLEN-1:0] q,
                                           input logic [XLEN-1:0] r);
    logic [XLEN-1:0] s;
    s = rem_sel ? r : q;
    if (word) s = {{(XLEN-32){s[31]}}, s[31:0]};
    return s;
  endfunction

  // Operand preparation and local special-case resolution.
  always_comb begin
    sgn = ~bus.op_i[0];
    if (bus.word_i) begin
      op1_p = sgn ? {{(XLEN-32){bus.rs1_i[31]}}, bus.rs1_i[31:0]}
                  : {{(XLEN-32){1'b0}}, bus.rs1_i[31:0]};
      op2_p = sgn ? {{(XLEN-32){bus.rs2_i[31]}}, bus.rs2_i[31:0]}
                  : {{(XLEN-32){1'b0}}, bus.rs2_i[31:0]};
    end else begin
      op1_p = bus.rs1_i;
      op2_p = bus.rs2_i;
    end
    div0    = (op2_p == '0);
    ovf     = sgn & (op1_p == MIN_VAL) & (op2_p == '1);
    ubig    = ~sgn & op2_p[XLEN-1];
    special = div0 | ovf | ubig;
    split   = ~sgn & op1_p[XLEN-1] & ~op2_p[XLEN-1];
    sq = '0;
    sr = '0;
    if (div0) begin
      sq = '1;
      sr = op1_p;
    end else if (ovf) begin
      sq = MIN_VAL;
      sr = '0;
    end else if (ubig) begin
      if (op1_p >= op2_p) begin
        sq = XLEN'(1'b1);
        sr = op1_p - op2_p;
      end else begin
        sq = '0;
        sr = op1_p;
      end
    end
  end

  // Final restoring step for the split unsigned divide: the core divided
  // op1>>1, so shift the dropped dividend bit back into the remainder.
  always_comb begin
    r2 = (rem_q << 1) | XLEN'(lsb_q);
    if (r2 >= div_op2) begin
      fix_q = (quo_q << 1) | XLEN'(1'b1);
      fix_r = r2 - div_op2;
    end else begin
      fix_q = quo_q << 1;
      fix_r = r2;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_rdy   <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_tag_q <= '0;
      busy      <= 1'b0;
      div_vld   <= 1'b0;
      div_op1   <= '0;
      div_op2   <= '0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      tag_q     <= '0;
      split_q   <= 1'b0;
      seen_q    <= 1'b0;
      lsb_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.flush_i) begin
            req_rdy <= 1'b1;
          end else if (bus.req_vld_i && req_rdy) begin
            req_rdy   <= 1'b0;
            busy      <= 1'b1;
            rem_sel_q <= bus.op_i[1];
            word_q    <= bus.word_i;
            tag_q     <= bus.tag_i;
            if (special) begin
              res_q     <= pick(bus.op_i[1], bus.word_i, sq, sr);
              res_tag_q <= bus.tag_i;
              res_vld_q <= 1'b1;
              state     <= S_DONE;
            end else begin
              div_vld <= 1'b1;
              div_op1 <= split ? (op1_p >> 1) : op1_p;
              div_op2 <= op2_p;
              split_q <= split;
              lsb_q   <= op1_p[0];
              seen_q  <= 1'b0;
              state   <= S_ISSUE;
            end
          end else begin
            req_rdy <= 1'b1;
          end
        end
        // Core acceptance is a ready 1 -> 0 transition seen while requesting.
        S_ISSUE: begin
          if (bus.flush_i) begin
            div_vld <= 1'b0;
            state   <= S_IDLE;
            req_rdy <= 1'b1;
            busy    <= 1'b0;
          end else if (bus.div_ready_i) begin
            seen_q <= 1'b1;
          end else if (seen_q) begin
            div_vld <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush_i) begin
            state <= S_DRAIN;
          end else if (bus.div_ready_i) begin
            quo_q <= bus.div_quo_i;
            rem_q <= bus.div_rem_i;
            if (split_q) begin
              state <= S_FIX;
            end else begin
              res_q     <= pick(rem_sel_q, word_q, bus.div_quo_i, bus.div_rem_i);
              res_tag_q <= tag_q;
              res_vld_q <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_FIX: begin
          if (bus.flush_i) begin
            state   <= S_IDLE;
            req_rdy <= 1'b1;
            busy    <= 1'b0;
          end else begin
            res_q     <= pick(rem_sel_q, word_q, fix_q, fix_r);
            res_tag_q <= tag_q;
            res_vld_q <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          res_vld_q <= 1'b0;
          state     <= S_IDLE;
          req_rdy   <= 1'b1;
          busy      <= 1'b0;
        end
        S_DRAIN: begin
          if (bus.div_ready_i) begin
            state   <= S_IDLE;
            req_rdy <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_rdy   <= 1'b1;
          busy      <= 1'b0;
          div_vld   <= 1'b0;
          res_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush in the result cycle kills the writeback pulse.
  assign bus.res_vld_o = res_vld_q & ~bus.flush_i;
  assign bus.req_rdy_o = req_rdy;
  assign bus.res_o     = res_q;
  assign bus.res_tag_o = res_tag_q;
  assign bus.busy_o    = busy;
  assign bus.div_vld_o = div_vld;
  assign bus.div_op1_o = div_op1;
  assign bus.div_op2_o = div_op2;

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Testbench for rv_div_ctrl: behavioural divider core with random latency,
// arithmetic reference model of RISC-V divide semantics, directed plus
// random ops, flush/drain and reset-in-flight scenarios.
module tb_rv_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   vld_cycles = 0;
  int   lat_fixed = -1;
  logic core_busy = 1'b0;
  int   core_cnt = 0;
  logic [63:0] core_a = '0;
  logic [63:0] core_b = '0;

  rv_div_ctrl_if #(.XLEN(64), .TAG_W(5)) bus ();

  rv_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural divider core: truncating signed divide, ready low while busy.
  always @(posedge clk) begin
    if (rst) begin
      bus.div_ready_i <= 1'b1;
      core_busy       <= 1'b0;
      core_cnt        <= 0;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        longint x, y;
        x = core_a;
        y = core_b;
        if (y == 0) begin
          bus.div_quo_i <= '1;
          bus.div_rem_i <= core_a;
        end else if (x == 64'sh8000_0000_0000_0000 && y == -1) begin
          bus.div_quo_i <= core_a;
          bus.div_rem_i <= '0;
        end else begin
          bus.div_quo_i <= 64'(x / y);
          bus.div_rem_i <= 64'(x % y);
        end
        bus.div_ready_i <= 1'b1;
        core_busy       <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else if (bus.div_vld_o && bus.div_ready_i) begin
      core_a          <= bus.div_op1_o;
      core_b          <= bus.div_op2_o;
      core_busy       <= 1'b1;
      bus.div_ready_i <= 1'b0;
      core_cnt        <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
    end
  end

  always @(posedge clk) if (bus.div_vld_o) vld_cycles <= vld_cycles + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // RISC-V M-extension result computed directly from the ISA rules.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    if (w) begin
      logic [31:0] q32, r32;
      if (!op[0]) begin
        int x, y;
        x = a[31:0];
        y = b[31:0];
        if (y == 0) begin q32 = '1; r32 = x; end
        else if (x == 32'sh8000_0000 && y == -1) begin q32 = x; r32 = '0; end
        else begin q32 = x / y; r32 = x % y; end
      end else begin
        int unsigned x, y;
        x = a[31:0];
        y = b[31:0];
        if (y == 0) begin q32 = '1; r32 = x; end
        else begin q32 = x / y; r32 = x % y; end
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else if (!op[0]) begin
      longint x, y;
      x = a;
      y = b;
      if (y == 0) begin q = '1; r = a; end
      else if (x == 64'sh8000_0000_0000_0000 && y == -1) begin q = a; r = '0; end
      else begin q = 64'(x / y); r = 64'(x % y); end
    end else begin
      if (b == 0) begin q = '1; r = a; end
      else begin q = a / b; r = a % b; end
    end
    return op[1] ? r : q;
  endfunction

  // Ops the controller must finish without the core.
  function automatic bit ref_special(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    bit sgn;
    sgn = !op[0];
    if (w) begin
      x = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
      y = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
    end else begin
      x = a;
      y = b;
    end
    return (y == 0) || (sgn && x == 64'h8000_0000_0000_0000 && y == '1) || (!sgn && y[63]);
  endfunction

  function automatic logic [63:0] rnd_val();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 20));
      2: v = '0;
      3: v = 64'h8000_0000_0000_0000;
      4: v = '1;
      5: v = {$urandom, $urandom | 32'h8000_0000};
      default: v = -64'($urandom_range(1, 20));
    endcase
    return v;
  endfunction

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!bus.req_rdy_o && n < 100) begin @(negedge clk); n++; end
    chk("req_rdy_wait", 64'(bus.req_rdy_o), 64'd1);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
    bus.req_vld_i = 1'b1;
    bus.op_i      = op;
    bus.word_i    = w;
    bus.rs1_i     = a;
    bus.rs2_i     = b;
    bus.tag_i     = tag;
    @(negedge clk);
    bus.req_vld_i = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    logic [63:0] exp;
    bit spec, got;
    int v0, n;
    exp  = ref_res(op, w, a, b);
    spec = ref_special(op, w, a, b);
    wait_rdy();
    v0 = vld_cycles;
    drive_req(op, w, a, b, tag);
    n = 1;
    got = 1'b0;
    while (n < 200) begin
      if (bus.res_vld_o) begin got = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    chk({name, "_res_vld"}, 64'(got), 64'd1);
    chk({name, "_res"}, bus.res_o, exp);
    chk({name, "_tag"}, 64'(bus.res_tag_o), 64'(tag));
    if (spec) begin
      chk({name, "_latency"}, 64'(n), 64'd1);
      chk({name, "_no_core"}, 64'(vld_cycles), 64'(v0));
    end else begin
      chk({name, "_core_used"}, 64'(vld_cycles > v0), 64'd1);
    end
    @(negedge clk);
    chk({name, "_pulse_len"}, 64'(bus.res_vld_o), 64'd0);
  endtask

  initial begin
    bus.req_vld_i = 1'b0;
    bus.op_i      = '0;
    bus.word_i    = 1'b0;
    bus.rs1_i     = '0;
    bus.rs2_i     = '0;
    bus.tag_i     = '0;
    bus.flush_i   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(bus.req_rdy_o), 64'd0);
    chk("rst_res_vld", 64'(bus.res_vld_o), 64'd0);
    chk("rst_res", bus.res_o, 64'd0);
    chk("rst_tag", 64'(bus.res_tag_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_div_vld", 64'(bus.div_vld_o), 64'd0);
    chk("rst_op1", bus.div_op1_o, 64'd0);
    chk("rst_op2", bus.div_op2_o, 64'd0);
    rst = 1'b0;

    // directed cases
    do_op("div_m7_2", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    chk("div_m7_2_val", bus.res_o, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("rem_m7_2", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
    do_op("divu_by0", 2'b01, 1'b0, 64'd5, 64'd0, 5'd5);
    do_op("remu_by0", 2'b11, 1'b0, 64'd5, 64'd0, 5'd6);
    do_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd7);
    do_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8);
    do_op("divu_split", 2'b01, 1'b0, '1, 64'd3, 5'd9);
    chk("divu_split_core_op1", core_a, 64'h7FFF_FFFF_FFFF_FFFF);
    do_op("remu_split", 2'b11, 1'b0, '1, 64'd3, 5'd10);
    do_op("remu_split_odd", 2'b11, 1'b0, 64'hF000_0000_0000_0001, 64'd10, 5'd11);
    do_op("divu_bigdiv", 2'b01, 1'b0, '1, 64'h8000_0000_0000_0001, 5'd12);
    do_op("remu_bigdiv", 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h9000_0000_0000_0000, 5'd13);
    do_op("divuw", 2'b01, 1'b1, 64'h1_8000_0000, 64'd1, 5'd14);
    do_op("remw", 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd15);
    do_op("divw_ovf", 2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd16);

    // flush together with a request in IDLE: flush wins
    wait_rdy();
    bus.flush_i = 1'b1;
    drive_req(2'b00, 1'b0, 64'd9, 64'd3, 5'd17);
    bus.flush_i = 1'b0;
    chk("idle_flush_busy", 64'(bus.busy_o), 64'd0);
    chk("idle_flush_rdy", 64'(bus.req_rdy_o), 64'd1);
    @(negedge clk);
    chk("idle_flush_no_res", 64'(bus.res_vld_o), 64'd0);

    // flush one cycle after the core accepted: drain, no writeback
    lat_fixed = 6;
    begin
      int n;
      wait_rdy();
      drive_req(2'b00, 1'b0, 64'd50, 64'd3, 5'd18);
      n = 0;
      while (bus.div_ready_i && n < 50) begin @(negedge clk); n++; end
      chk("flush_core_accepted", 64'(bus.div_ready_i), 64'd0);
      @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      n = 0;
      while (!bus.div_ready_i && n < 50) begin
        chk("drain_busy", 64'(bus.busy_o), 64'd1);
        chk("drain_no_res", 64'(bus.res_vld_o), 64'd0);
        @(negedge clk);
        n++;
      end
      chk("drain_core_done", 64'(bus.div_ready_i), 64'd1);
      chk("drain_busy_last", 64'(bus.busy_o), 64'd1);
      chk("drain_rdy_last", 64'(bus.req_rdy_o), 64'd0);
      @(negedge clk);
      chk("drain_exit_busy", 64'(bus.busy_o), 64'd0);
      chk("drain_exit_rdy", 64'(bus.req_rdy_o), 64'd1);
      chk("drain_exit_no_res", 64'(bus.res_vld_o), 64'd0);
    end
    lat_fixed = -1;
    do_op("div_100_7", 2'b00, 1'b0, 64'd100, 64'd7, 5'd19);
    chk("div_100_7_val", bus.res_o, 64'd14);

    // reset while the core is busy
    lat_fixed = 5;
    begin
      int n;
      wait_rdy();
      drive_req(2'b01, 1'b0, 64'd1000, 64'd9, 5'd20);
      n = 0;
      while (bus.div_ready_i && n < 50) begin @(negedge clk); n++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 64'(bus.busy_o), 64'd0);
      chk("midrst_div_vld", 64'(bus.div_vld_o), 64'd0);
      chk("midrst_res_vld", 64'(bus.res_vld_o), 64'd0);
    end
    lat_fixed = -1;
    do_op("after_rst", 2'b10, 1'b0, 64'd1000, 64'd9, 5'd21);

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      do_op("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rnd_val(), rnd_val(), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
